prbs_stream_check: RTL and testbench
====================================

// Module: prbs_stream_check
// PURPOSE
//  Receive-side PRBS checker, the counterpart of rng_stream: accepts DATA_WIDTH-bit PRBS words and
//  self-synchronises a feed-forward LFSR descrambler (rand_lfsr, LFSR_FEED_FORWARD=1) to them.
//  Flags per-word bit errors and runs a HUNT/LOCKED lock FSM. Keeps saturating bit/word error
//  counters for link BIST and RNG loopback self-test.
// PARAMETERS
//  LFSR_WIDTH    31              LFSR length; must match the generator
//  LFSR_POLY     31'h10a00001    polynomial, top term implied; must match the generator
//  LFSR_CONFIG   "FIBONACCI"     "FIBONACCI" or "GALOIS", passed to rand_lfsr
//  REVERSE       0               bit-reverse input/shift order, passed to rand_lfsr
//  INVERT        1               input is an inverted PRBS; XOR with all-ones before descrambling
//  DATA_WIDTH    8               input word width
//  STYLE         "AUTO"          rand_lfsr implementation style
//  LOCK_COUNT    16              consecutive error-free words needed for HUNT->LOCKED (>=1)
//  UNLOCK_COUNT  4               consecutive errored words needed for LOCKED->HUNT (>=1)
//  CNT_WIDTH     32              width of the error counters
// PORTS
//  clk           in   1              clock
//  rst           in   1              sync active-high reset
//  data_in       in   DATA_WIDTH     received PRBS word
//  data_valid    in   1              data_in valid this cycle; no backpressure
//  cnt_clear     in   1              sync clear of both error counters
//  err_bits      out  DATA_WIDTH     registered per-bit error vector of the last valid word
//  err_valid     out  1              err_bits updated this cycle
//  locked        out  1              lock FSM is in LOCKED
//  bit_err_cnt   out  CNT_WIDTH      saturating count of errored bits while locked
//  word_err_cnt  out  CNT_WIDTH      saturating count of errored words while locked
// BEHAVIOUR
//  Reset: state_reg=0, err_bits=0, err_valid=0, locked=0, both counters=0,
//    run counters=0, FSM=HUNT. Reset mid-stream discards sync; resync then needs fill + LOCK_COUNT words.
//  Datapath: d = INVERT ? ~data_in : data_in.
//    rand_lfsr(data_in=d, state_in=state_reg) -> e (data_out), s (state_out).
//    On data_valid, state_reg<=s; state is fed from received data, so it self-synchronises.
//  Error flags: on data_valid, err_bits<=e and err_valid<=1 the next cycle (1-cycle latency).
//    With no data_valid: err_valid<=0 and err_bits holds.
//  Fill: the first ceil(LFSR_WIDTH/DATA_WIDTH) words after reset/HUNT entry give garbage e.
//    The FSM absorbs these in HUNT; the counters do not count them.
//  Error multiplication: one flipped input bit yields weight(poly)+1 error bits,
//    spread over the following LFSR_WIDTH bits.
//  Lock FSM (advances only on data_valid; word_err = |e):
//    HUNT:   clean word -> good_run++, else good_run=0; good_run reaching LOCK_COUNT -> LOCKED, good_run=0.
//    LOCKED: errored word -> bad_run++, else bad_run=0; bad_run reaching UNLOCK_COUNT -> HUNT, bad_run=0.
//    locked is registered and changes in the cycle after the deciding word, with err_valid.
//  Counters: update only for words processed while the FSM is in LOCKED,
//    including the word that causes LOCKED->HUNT.
//    bit_err_cnt += popcount(e); word_err_cnt += word_err.
//    Both saturate at all-ones and never wrap; saturating add is computed at CNT_WIDTH+1 bits.
//  cnt_clear: takes priority; counters go to 0 and the same-cycle word's errors are discarded.
//    Does not affect the FSM or the LFSR.
//  data_valid low: no state changes except err_valid<=0.
// TESTING
//  1 DUT POLY=31'h10000001, INVERT=1, DW=8, plus a matching generator, enable=1 continuously
//    -> locked rises after 4 fill + 16 clean words (within cycle 21); counters stay 0 for 10k words.
//  2 While locked, flip data_in[0] in a single word -> bit_err_cnt=3 after the error fades;
//    word_err_cnt is 2 or 3; locked stays 1.
//  3 While locked, drive data_in=8'h00 for 4 words -> locked falls 1 cycle after the 4th word;
//    resume the PRBS -> relock after 4+16 words.
//  4 Toggle data_valid at random 50% duty -> same lock point counted in valid words;
//    err_valid only follows valid words.
//  5 CNT_WIDTH=4, inject repeated errors -> counters stop at 4'hF.
//    cnt_clear asserted with an errored word -> next cycle both counters = 0.
//  6 Assert rst while locked -> next cycle all outputs 0 and FSM=HUNT; relocks per scenario 1.

Source files
------------

// File: rtl/prbs_stream_check.sv
// Receive-side PRBS checker: self-synchronising feed-forward LFSR descrambler,
// per-word error flags, HUNT/LOCKED lock FSM and saturating bit/word error counters.
module prbs_stream_check #(
  parameter int                    LFSR_WIDTH   = 31,
  parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 31'h10a00001,
  parameter string                 LFSR_CONFIG  = "FIBONACCI",
  parameter int                    REVERSE      = 0,
  parameter int                    INVERT       = 1,
  parameter int                    DATA_WIDTH   = 8,
  parameter string                 STYLE        = "AUTO",
  parameter int                    LOCK_COUNT   = 16,
  parameter int                    UNLOCK_COUNT = 4,
  parameter int                    CNT_WIDTH    = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  input  logic                  cnt_clear,
  output logic [DATA_WIDTH-1:0] err_bits,
  output logic                  err_valid,
  output logic                  locked,
  output logic [CNT_WIDTH-1:0]  bit_err_cnt,
  output logic [CNT_WIDTH-1:0]  word_err_cnt
);

  localparam int IN_W    = LFSR_WIDTH + DATA_WIDTH;
  localparam int RUN_MAX = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int RUN_W   = $clog2(RUN_MAX + 1);
  localparam int POP_W   = $clog2(DATA_WIDTH + 1);
  localparam bit IS_GALOIS = (LFSR_CONFIG == "GALOIS");
  localparam bit USE_LOOP  = (STYLE == "LOOP");

  localparam logic [0:0] ST_HUNT   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  // Bit-serial feed-forward descrambler over one word; returns {next_state, error_bits}.
  // The state only ever shifts in received bits, which is what makes it self-synchronise.
  function automatic logic [IN_W-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] st,
                                                input logic [DATA_WIDTH-1:0] din);
    logic [LFSR_WIDTH-1:0] s;
    logic [DATA_WIDTH-1:0] e;
    logic                  b;
    logic                  fb;
    int                    k;
    s = st;
    e = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      k  = (REVERSE != 0) ? i : DATA_WIDTH - 1 - i;
      b  = din[k];
      fb = s[LFSR_WIDTH-1];
      if (IS_GALOIS) begin
        e[k] = fb ^ b;
        s = {s[LFSR_WIDTH-2:0], b} ^ ({LFSR_WIDTH{b}} & {LFSR_POLY[LFSR_WIDTH-1:1], 1'b0});
      end else begin
        for (int j = 1; j < LFSR_WIDTH; j++) begin
          if (LFSR_POLY[j]) fb = fb ^ s[j-1];
        end
        e[k] = fb ^ b;
        s = {s[LFSR_WIDTH-2:0], b};
      end
    end
    return {s, e};
  endfunction

  // The step is linear over GF(2), so each output bit is the parity of a fixed input mask.
  function automatic logic [IN_W-1:0] row_mask(input int r);
    logic [IN_W-1:0] m;
    logic [IN_W-1:0] unit;
    logic [IN_W-1:0] col;
    m = '0;
    for (int c = 0; c < IN_W; c++) begin
      unit    = '0;
      unit[c] = 1'b1;
      col     = lfsr_step(unit[IN_W-1:DATA_WIDTH], unit[DATA_WIDTH-1:0]);
      m[c]    = col[r];
    end
    return m;
  endfunction

  logic [LFSR_WIDTH-1:0] state_q, state_d;
  logic [DATA_WIDTH-1:0] err_bits_q, err_bits_d;
  logic                  err_valid_q, err_valid_d;
  logic [0:0]            fsm_q, fsm_d;
  logic [RUN_W-1:0]      run_q, run_d;
  logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;

  logic [DATA_WIDTH-1:0] data_inv;
  logic [IN_W-1:0]       lfsr_in;
  logic [IN_W-1:0]       lfsr_out;
  logic [DATA_WIDTH-1:0] err_e;
  logic                  word_err;
  logic [POP_W-1:0]      pop;
  logic [CNT_WIDTH:0]    bit_sum;
  logic [CNT_WIDTH:0]    word_sum;

  assign data_inv = (INVERT != 0) ? ~data_in : data_in;
  assign lfsr_in  = {state_q, data_inv};

  generate
    if (USE_LOOP) begin : g_loop
      assign lfsr_out = lfsr_step(lfsr_in[IN_W-1:DATA_WIDTH], lfsr_in[DATA_WIDTH-1:0]);
    end else begin : g_matrix
      for (genvar gi = 0; gi < IN_W; gi++) begin : g_row
        localparam logic [IN_W-1:0] MASK = row_mask(gi);
        assign lfsr_out[gi] = ^(MASK & lfsr_in);
      end
    end
  endgenerate

  assign err_e    = lfsr_out[DATA_WIDTH-1:0];
  assign word_err = |err_e;
  assign pop      = POP_W'($countones(err_e));
  assign bit_sum  = {1'b0, bit_cnt_q} + (CNT_WIDTH+1)'(pop);
  assign word_sum = {1'b0, word_cnt_q} + (CNT_WIDTH+1)'(word_err);

  always_comb begin
    state_d     = state_q;
    err_bits_d  = err_bits_q;
    err_valid_d = data_valid;
    if (data_valid) begin
      state_d    = lfsr_out[IN_W-1:DATA_WIDTH];
      err_bits_d = err_e;
    end
  end

  // One run counter serves as good_run in HUNT and bad_run in LOCKED.
  always_comb begin
    fsm_d = fsm_q;
    run_d = run_q;
    if (data_valid) begin
      if (fsm_q == ST_HUNT) begin
        if (word_err) begin
          run_d = '0;
        end else if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
          fsm_d = ST_LOCKED;
          run_d = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end else begin
        if (!word_err) begin
          run_d = '0;
        end else if (run_q == RUN_W'(UNLOCK_COUNT - 1)) begin
          fsm_d = ST_HUNT;
          run_d = '0;
        end else begin
          run_d = run_q + RUN_W'(1);
        end
      end
    end
  end

  always_comb begin
    bit_cnt_d  = bit_cnt_q;
    word_cnt_d = word_cnt_q;
    if (cnt_clear) begin
      bit_cnt_d  = '0;
      word_cnt_d = '0;
    end else if (data_valid && fsm_q == ST_LOCKED) begin
      bit_cnt_d  = bit_sum[CNT_WIDTH]  ? '1 : bit_sum[CNT_WIDTH-1:0];
      word_cnt_d = word_sum[CNT_WIDTH] ? '1 : word_sum[CNT_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= '0;
      err_bits_q  <= '0;
      err_valid_q <= 1'b0;
      fsm_q       <= ST_HUNT;
      run_q       <= '0;
      bit_cnt_q   <= '0;
      word_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      err_bits_q  <= err_bits_d;
      err_valid_q <= err_valid_d;
      fsm_q       <= fsm_d;
      run_q       <= run_d;
      bit_cnt_q   <= bit_cnt_d;
      word_cnt_q  <= word_cnt_d;
    end
  end

  assign err_bits     = err_bits_q;
  assign err_valid    = err_valid_q;
  assign locked       = (fsm_q == ST_LOCKED);
  assign bit_err_cnt  = bit_cnt_q;
  assign word_err_cnt = word_cnt_q;

endmodule

// File: tb/tb_prbs_stream_check.sv
// Bench for prbs_stream_check: PRBS31 (x^31+x^28+1) generator drives two checkers,
// one with 32-bit counters (matrix style) and one with 4-bit counters (loop style).
module tb_prbs_stream_check;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_valid;
  logic       clr_a, clr_b;

  logic [7:0]  err_bits_a, err_bits_b;
  logic        err_valid_a, err_valid_b;
  logic        locked_a, locked_b;
  logic [31:0] bit_cnt_a, word_cnt_a;
  logic [3:0]  bit_cnt_b, word_cnt_b;

  always #5 clk = ~clk;

  prbs_stream_check #(.LFSR_POLY(31'h10000001), .INVERT(1), .DATA_WIDTH(8), .CNT_WIDTH(32)) dut_a (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .cnt_clear(clr_a),
    .err_bits(err_bits_a), .err_valid(err_valid_a), .locked(locked_a),
    .bit_err_cnt(bit_cnt_a), .word_err_cnt(word_cnt_a));

  prbs_stream_check #(.LFSR_POLY(31'h10000001), .INVERT(1), .DATA_WIDTH(8), .CNT_WIDTH(4),
                      .STYLE("LOOP")) dut_b (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid), .cnt_clear(clr_b),
    .err_bits(err_bits_b), .err_valid(err_valid_b), .locked(locked_b),
    .bit_err_cnt(bit_cnt_b), .word_err_cnt(word_cnt_b));

  typedef struct {
    logic       v;
    logic [7:0] flip;
    logic       ev;
    logic [7:0] eb;
    logic       lk;
    int         bc;
    int         wc;
  } vec_t;

  vec_t        tbl [40];
  int          n_vec = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [30:0] g_state;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference PRBS31 generator, MSB of the word transmitted first.
  task automatic gen_word(output logic [7:0] w);
    logic fb;
    for (int b = 7; b >= 0; b--) begin
      fb      = g_state[30] ^ g_state[27];
      w[b]    = fb;
      g_state = {g_state[29:0], fb};
    end
  endtask

  task automatic step(input logic v, input logic [7:0] flip, input logic use_raw,
                      input logic [7:0] raw, input logic ca, input logic cb);
    logic [7:0] w;
    if (v) begin
      gen_word(w);
      data_in = use_raw ? raw : (~w ^ flip);
    end else begin
      data_in = 8'($urandom);
    end
    data_valid = v;
    clr_a      = ca;
    clr_b      = cb;
    @(posedge clk);
    #1;
    $display("cyc rst=%0b v=%0b din=%02h | A ev=%0b eb=%02h lk=%0b bc=%0d wc=%0d | B lk=%0b bc=%0d wc=%0d",
             rst, v, data_in, err_valid_a, err_bits_a, locked_a, bit_cnt_a, word_cnt_a,
             locked_b, bit_cnt_b, word_cnt_b);
  endtask

  task automatic send_word(input logic [7:0] flip);
    step(1'b1, flip, 1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  task automatic add_vec(input logic v, input logic [7:0] flip, input logic [7:0] eb,
                         input logic lk, input int bc, input int wc);
    tbl[n_vec].v    = v;
    tbl[n_vec].flip = flip;
    tbl[n_vec].ev   = v;
    tbl[n_vec].eb   = eb;
    tbl[n_vec].lk   = lk;
    tbl[n_vec].bc   = bc;
    tbl[n_vec].wc   = wc;
    n_vec++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_err_bits_a"},  32'(err_bits_a),  32'd0);
    check({tag, "_err_valid_a"}, 32'(err_valid_a), 32'd0);
    check({tag, "_locked_a"},    32'(locked_a),    32'd0);
    check({tag, "_bit_cnt_a"},   bit_cnt_a,        32'd0);
    check({tag, "_word_cnt_a"},  word_cnt_a,       32'd0);
    check({tag, "_locked_b"},    32'(locked_b),    32'd0);
    check({tag, "_bit_cnt_b"},   32'(bit_cnt_b),   32'd0);
  endtask

  // Feeds up to 20 words after a fresh HUNT; lock needs 16 clean words after at most 4 fill words.
  task automatic relock(input string tag);
    int lock_at;
    lock_at = 0;
    for (int k = 1; k <= 20; k++) begin
      send_word(8'h00);
      if (k == 15) check({tag, "_locked_after15"}, 32'(locked_a), 32'd0);
      if (locked_a && lock_at == 0) lock_at = k;
    end
    check({tag, "_relock_16_to_20"}, 32'(lock_at >= 16 && lock_at <= 20), 32'd1);
  endtask

  initial begin
    logic [7:0]  acc;
    logic [7:0]  la [4];
    logic [30:0] save;
    int          tries;
    int          nvalid;
    int          cyc;
    logic        v;
    logic [7:0]  last_eb;

    rst = 1'b1; data_in = 8'h00; data_valid = 1'b0; clr_a = 1'b0; clr_b = 1'b0;
    g_state = '1;

    // From reset with an all-ones seed: stream bits 28..30 are the only fill errors (word 4 = 0E).
    add_vec(1, 8'h00, 8'h00, 0, 0, 0);
    add_vec(1, 8'h00, 8'h00, 0, 0, 0);
    add_vec(1, 8'h00, 8'h00, 0, 0, 0);
    add_vec(0, 8'h00, 8'h00, 0, 0, 0);
    add_vec(1, 8'h00, 8'h0E, 0, 0, 0);
    add_vec(0, 8'h00, 8'h0E, 0, 0, 0);
    for (int i = 5; i <= 19; i++) add_vec(1, 8'h00, 8'h00, 0, 0, 0);
    add_vec(1, 8'h00, 8'h00, 1, 0, 0);
    for (int i = 0; i < 3; i++) add_vec(1, 8'h00, 8'h00, 1, 0, 0);
    // Flip of data_in[0] reappears 28 and 31 bits later: word+4 bits [4] and [1].
    add_vec(1, 8'h01, 8'h01, 1, 1, 1);
    for (int i = 0; i < 3; i++) add_vec(1, 8'h00, 8'h00, 1, 1, 1);
    add_vec(1, 8'h00, 8'h12, 1, 3, 2);
    for (int i = 0; i < 4; i++) add_vec(1, 8'h00, 8'h00, 1, 3, 2);

    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int i = 0; i < n_vec; i++) begin
      step(tbl[i].v, tbl[i].flip, 1'b0, 8'h00, 1'b0, 1'b0);
      check($sformatf("vec%0d_err_valid", i), 32'(err_valid_a), 32'(tbl[i].ev));
      check($sformatf("vec%0d_err_bits", i),  32'(err_bits_a),  32'(tbl[i].eb));
      check($sformatf("vec%0d_locked", i),    32'(locked_a),    32'(tbl[i].lk));
      check($sformatf("vec%0d_bit_cnt", i),   bit_cnt_a,        32'(tbl[i].bc));
      check($sformatf("vec%0d_word_cnt", i),  word_cnt_a,       32'(tbl[i].wc));
    end
    check("vec_locked_b", 32'(locked_b), 32'd1);

    // Long clean run: nothing flagged, counters hold.
    acc = 8'h00;
    for (int i = 0; i < 3000; i++) begin
      send_word(8'h00);
      acc = acc | err_bits_a;
    end
    check("clean_err_or", 32'(acc), 32'd0);
    check("clean_locked", 32'(locked_a), 32'd1);
    check("clean_bit_cnt", bit_cnt_a, 32'd3);
    check("clean_word_cnt", word_cnt_a, 32'd2);

    // Pick a point where four 8'h00 words are each guaranteed to be errored.
    tries = 0;
    forever begin
      save = g_state;
      for (int k = 0; k < 4; k++) gen_word(la[k]);
      g_state = save;
      if (la[0] != 8'hFF && la[1] != 8'hFF && la[2] != 8'hFF && la[3][7:4] != 4'hF) break;
      send_word(8'h00);
      tries++;
      if (tries > 64) begin
        check("zero_guard_tries", 32'(tries), 32'd0);
        break;
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b1, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      check($sformatf("zero%0d_locked", k), 32'(locked_a), (k < 3) ? 32'd1 : 32'd0);
    end
    check("zero_word_cnt", word_cnt_a, 32'd6);
    relock("resume");
    check("resume_word_cnt", word_cnt_a, 32'd6);

    // Random data_valid from a fresh reset: lock lands on the 20th valid word.
    rst = 1'b1;
    step(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    g_state = '1;
    nvalid  = 0;
    cyc     = 0;
    last_eb = 8'h00;
    while (nvalid < 20 && cyc < 400) begin
      v = 1'($urandom_range(0, 1));
      step(v, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      cyc++;
      if (v) begin
        nvalid++;
        last_eb = (nvalid == 4) ? 8'h0E : 8'h00;
      end
      check($sformatf("rv%0d_err_valid", cyc), 32'(err_valid_a), 32'(v));
      check($sformatf("rv%0d_err_bits", cyc), 32'(err_bits_a), 32'(last_eb));
      if (v && nvalid == 19) check("rv_locked_at19", 32'(locked_a), 32'd0);
      if (v && nvalid == 20) check("rv_locked_at20", 32'(locked_a), 32'd1);
    end
    check("rv_valid_words", 32'(nvalid), 32'd20);

    // Repeated single-bit errors: 3 bits / 2 words each; 4-bit counters saturate at F.
    for (int k = 1; k <= 12; k++) begin
      send_word(8'h01);
      for (int j = 0; j < 4; j++) send_word(8'h00);
      check($sformatf("sat%0d_bit_a", k),  bit_cnt_a,  32'(3 * k));
      check($sformatf("sat%0d_word_a", k), word_cnt_a, 32'(2 * k));
      check($sformatf("sat%0d_bit_b", k),  32'(bit_cnt_b),  32'((3 * k > 15) ? 15 : 3 * k));
      check($sformatf("sat%0d_word_b", k), 32'(word_cnt_b), 32'((2 * k > 15) ? 15 : 2 * k));
      check($sformatf("sat%0d_locked", k), 32'(locked_a), 32'd1);
    end

    // Clear on dut_b coincides with an errored word; that word is dropped there only.
    step(1'b1, 8'h01, 1'b0, 8'h00, 1'b0, 1'b1);
    check("clr_bit_b", 32'(bit_cnt_b), 32'd0);
    check("clr_word_b", 32'(word_cnt_b), 32'd0);
    check("clr_bit_a", bit_cnt_a, 32'd37);
    check("clr_word_a", word_cnt_a, 32'd25);
    for (int j = 0; j < 4; j++) send_word(8'h00);
    check("postclr_bit_b", 32'(bit_cnt_b), 32'd2);
    check("postclr_word_b", 32'(word_cnt_b), 32'd1);
    check("postclr_bit_a", bit_cnt_a, 32'd39);
    check("postclr_word_a", word_cnt_a, 32'd26);

    // Reset while locked, with a valid word present.
    rst = 1'b1;
    step(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
    check_reset_outputs("midreset");
    rst = 1'b0;
    relock("midreset");
    check("midreset_bit_cnt", bit_cnt_a, 32'd0);
    check("midreset_word_cnt", word_cnt_a, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
